// File: rtl/pair_exit_drain.sv
// pair_exit_drain: pops pair words from the slot-sampled exit FIFO and streams them as 64-bit beats plus a count trailer
module pair_exit_drain #(
    parameter int SLOT_CYCLES = 16,
    parameter int MAX_PAIRS   = 4096,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [191:0] pair_in,
    output logic         read_ctrl,
    output logic [63:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         busy,
    output logic         done
);
    localparam int WAIT_W = $clog2(2 * SLOT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(2 * SLOT_CYCLES - 1);
    typedef enum logic [3:0] {IDLE, SETTLE, SAMPLE, SEND0, SEND1, SEND2, POP_HI, POP_LO, TRAIL, DONE} state_t;
    state_t state, state_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic [CNT_W-1:0] pairs, pairs_n;
    logic [191:0] cap, cap_n;
    logic ovf, ovf_n;
    logic [15:0] cnt16;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            pairs     <= '0;
            cap       <= '0;
            ovf       <= 1'b0;
            read_ctrl <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            pairs     <= pairs_n;
            cap       <= cap_n;
            ovf       <= ovf_n;
            read_ctrl <= state_n == POP_HI;
        end
    end
    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        pairs_n = pairs;
        cap_n   = cap;
        ovf_n   = ovf;
        case (state)
            IDLE: if (start) begin
                state_n = SETTLE;
                pairs_n = '0;
                ovf_n   = 1'b0;
                wait_n  = WAIT_MAX;
            end
            SETTLE: if (wait_cnt == '0) state_n = SAMPLE;
                    else wait_n = wait_cnt - WAIT_W'(1);
            SAMPLE: begin
                cap_n = pair_in;
                if (pair_in == '0) state_n = TRAIL;
                else if (pairs == CNT_W'(MAX_PAIRS)) begin
                    state_n = TRAIL;
                    ovf_n   = 1'b1;
                end else state_n = SEND0;
            end
            SEND0: if (m_ready) state_n = SEND1;
            SEND1: if (m_ready) state_n = SEND2;
            SEND2: if (m_ready) begin
                state_n = POP_HI;
                pairs_n = pairs + CNT_W'(1);
                wait_n  = WAIT_MAX;
            end
            // each pop phase spans two slots so the FIFO sees the level at least once
            POP_HI: if (wait_cnt == '0) begin
                state_n = POP_LO;
                wait_n  = WAIT_MAX;
            end else wait_n = wait_cnt - WAIT_W'(1);
            POP_LO: if (wait_cnt == '0) state_n = SAMPLE;
                    else wait_n = wait_cnt - WAIT_W'(1);
            TRAIL: if (m_ready) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign cnt16   = 16'(pairs);
    assign m_valid = state inside {SEND0, SEND1, SEND2, TRAIL};
    assign m_last  = state == TRAIL;
    assign busy    = !(state inside {IDLE, DONE});
    assign done    = state == DONE;
    assign m_data  = state == SEND0 ? cap[63:0] :
                     state == SEND1 ? cap[127:64] :
                     state == SEND2 ? cap[191:128] :
                     state == TRAIL ? {16'hFFFF, 15'h0, ovf, 16'h0, cnt16} : '0;
endmodule

// File: tb/tb_pair_exit_drain.sv
// tb_pair_exit_drain: drains against a slot-sampled FWFT FIFO model, checked beat by beat against a queue of expected beats
module tb_pair_exit_drain;
    localparam int S = 16;
    localparam int MAXP = 3;
    localparam int CW = 4;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic [191:0] pair_in = '0;
    logic read_ctrl, m_valid, m_last, busy, done;
    logic [63:0] m_data;
    pair_exit_drain #(.SLOT_CYCLES(S), .MAX_PAIRS(MAXP), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .pair_in(pair_in), .read_ctrl(read_ctrl),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    // FIFO: samples read_ctrl and refreshes its head view only at slot boundaries
    logic [191:0] mem [0:127];
    int wr_ptr = 0, rd_ptr = 0, slot = 0;
    logic rc_seen = 1'b0;
    always @(posedge clk) begin
        slot <= (slot + 1) % S;
        if (slot == 0) begin
            rc_seen <= read_ctrl;
            if (read_ctrl && !rc_seen && rd_ptr < wr_ptr) begin
                rd_ptr  <= rd_ptr + 1;
                pair_in <= rd_ptr + 1 < wr_ptr ? mem[rd_ptr + 1] : '0;
            end else
                pair_in <= rd_ptr < wr_ptr ? mem[rd_ptr] : '0;
        end
    end
    int total = 0, bad = 0, cyc = 0, mode = 0, rises = 0, hs_cnt = 0, done_cyc = -1;
    logic active = 1'b0, hold_v = 1'b0, trail_prev = 1'b0, rc_prev = 1'b0;
    logic [63:0] hold_d = '0, last_trail = '0;
    logic [64:0] exp_q [$];
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask
    task automatic tick();
        logic [64:0] e;
        @(posedge clk);
        #1 m_ready = (mode == 0) || (mode == 1 && !m_ready) || (mode == 2 && $urandom_range(3) != 0);
        @(negedge clk);
        cyc++;
        if (!reset) begin
            chk("rst_valid", m_valid, 0);
            chk("rst_read_ctrl", read_ctrl, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_data", m_data, 0);
            exp_q.delete();
            active = 1'b0;
            hold_v = 1'b0;
            trail_prev = 1'b0;
        end else begin
            chk("busy", busy, active);
            chk("done", done, trail_prev);
            if (m_valid) chk("no_pop_in_send", read_ctrl, 0);
            if (hold_v) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, hold_d);
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got %h want no beat", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e[63:0]);
                    chk("beat_last", m_last, e[64]);
                end
                if (m_last) begin
                    active = 1'b0;
                    last_trail = m_data;
                end
            end
            trail_prev = m_valid && m_ready && m_last;
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            if (done) done_cyc = cyc;
        end
        if (read_ctrl && !rc_prev) rises++;
        rc_prev = read_ctrl;
    endtask
    task automatic load(input int n);
        logic [191:0] e;
        for (int i = 0; i < n; i++) begin
            e = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            e[191] = 1'b0;
            e[0] = 1'b1;
            mem[wr_ptr] = e;
            wr_ptr++;
        end
    endtask
    task automatic plan(output int avail, output int k);
        logic [191:0] e;
        avail = wr_ptr - rd_ptr;
        k = avail < MAXP ? avail : MAXP;
        for (int i = 0; i < k; i++) begin
            e = mem[rd_ptr + i];
            exp_q.push_back({1'b0, e[63:0]});
            exp_q.push_back({1'b0, e[127:64]});
            exp_q.push_back({1'b0, e[191:128]});
        end
        exp_q.push_back({1'b1, 16'hFFFF, 15'h0, avail > MAXP, 16'h0, 16'(k)});
    endtask
    task automatic drain(input int md, input bit dbl, input int want_len);
        int avail, k, r0, st;
        plan(avail, k);
        r0 = rises;
        mode = md;
        done_cyc = -1;
        st = cyc;
        start = 1'b1;
        active = 1'b1;
        tick();
        start = 1'b0;
        if (dbl) begin
            repeat (6) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int t = 0; t < 5000 && done_cyc < 0; t++) tick();
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got no done want done within 5000 cycles");
        end else if (want_len > 0) chk("drain_len", done_cyc - st, want_len);
        chk("pops", rises - r0, k);
        chk("left_in_fifo", wr_ptr - rd_ptr, avail - k);
        chk("beats_missing", exp_q.size(), 0);
        tick();
    endtask
    initial begin
        int avail, k, hs0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        drain(0, 1'b0, 35);
        chk("trailer_empty", last_trail, 64'hFFFF_0000_0000_0000);
        load(3);
        drain(0, 1'b0, 239);
        chk("trailer_three", last_trail, 64'hFFFF_0000_0000_0003);
        load(3);
        drain(1, 1'b0, 0);
        chk("trailer_toggle", last_trail, 64'hFFFF_0000_0000_0003);
        load(5);
        drain(0, 1'b0, 239);
        chk("trailer_overflow", last_trail, 64'hFFFF_0001_0000_0003);
        drain(2, 1'b0, 0);
        chk("trailer_leftover", last_trail, 64'hFFFF_0000_0000_0002);
        load(2);
        drain(0, 1'b1, 171);
        chk("trailer_dbl_start", last_trail, 64'hFFFF_0000_0000_0002);
        load(3);
        plan(avail, k);
        mode = 0;
        hs0 = hs_cnt;
        start = 1'b1;
        active = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 2000 && hs_cnt - hs0 < 4; t++) tick();
        chk("reach_pair2", hs_cnt - hs0, 4);
        mode = 3;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mode = 0;
        tick();
        chk("reset_left", wr_ptr - rd_ptr, 2);
        drain(0, 1'b0, 171);
        chk("trailer_after_reset", last_trail, 64'hFFFF_0000_0000_0002);
        for (int r = 0; r < 4; r++) begin
            load($urandom_range(4));
            drain(2, 1'b0, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
